// File: rtl/turing_pkg.sv
// Shared encodings for the Turing-machine sequencer: move codes, error codes,
// FSM state enum and the bit offsets of fields within a transition-table entry.
package turing_pkg;

    localparam logic [1:0] MV_STAY  = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BOUND   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Entry layout is {halt, wr_sym, move[1:0], next_q[Q_W-1:0]}; offsets above
    // next_q are relative to Q_W so the package stays width-agnostic.
    localparam int CFG_NEXTQ_LSB = 0;
    localparam int CFG_MOVE_OFS  = 0;
    localparam int CFG_WR_OFS    = 2;
    localparam int CFG_HALT_OFS  = 3;
    localparam int CFG_EXTRA_W   = 4;

endpackage

// File: rtl/turing_seq_if.sv
// Host-side bundle of the sequencer: table programming, run control and status.
// step_req exists only when TURING_SINGLE_STEP_EN is defined.
interface turing_seq_if #(
    parameter int TAPE_LEN = 10,
    parameter int Q_W      = 2,
    parameter int STEP_W   = 8
);
    localparam int HW = $clog2(TAPE_LEN);

    logic                  cfg_we;
    logic [Q_W:0]          cfg_addr;
    logic [Q_W+3:0]        cfg_data;
    logic                  start;
    logic [TAPE_LEN-1:0]   tape_in;
    logic [HW-1:0]         head_init;
`ifdef TURING_SINGLE_STEP_EN
    logic                  step_req;
`endif
    logic                  busy;
    logic                  done;
    logic [1:0]            err;
    logic [TAPE_LEN-1:0]   tape_out;
    logic [HW-1:0]         head;
    logic [Q_W-1:0]        q;
    logic [STEP_W-1:0]     steps;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, tape_in, head_init,
`ifdef TURING_SINGLE_STEP_EN
        output step_req,
`endif
        input  busy, done, err, tape_out, head, q, steps
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, tape_in, head_init,
`ifdef TURING_SINGLE_STEP_EN
        input  step_req,
`endif
        output busy, done, err, tape_out, head, q, steps
    );

endinterface

// File: rtl/turing_table.sv
// Transition table: 2**(Q_W+1) entries, synchronous write, combinational read.
// Not reset; contents must be programmed before the first run.
module turing_table
    import turing_pkg::*;
#(
    parameter int Q_W = 2
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [Q_W:0]             waddr,
    input  logic [Q_W+CFG_EXTRA_W-1:0] wdata,
    input  logic [Q_W:0]             raddr,
    output logic [Q_W+CFG_EXTRA_W-1:0] rdata
);

    logic [Q_W+CFG_EXTRA_W-1:0] mem [2**(Q_W+1)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/turing_seq.sv
// Programmable Turing-machine sequencer: one transition per clock until halt,
// boundary or step-limit. Optional TURING_SINGLE_STEP_EN gates steps on step_req.
module turing_seq
    import turing_pkg::*;
#(
    parameter int TAPE_LEN = 10,
    parameter int Q_W      = 2,
    parameter int STEP_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    turing_seq_if.slave  bus
);

    localparam int HW = $clog2(TAPE_LEN);
    localparam logic [HW-1:0]     LAST_CELL = HW'(TAPE_LEN - 1);
    localparam logic [HW:0]       TAPE_END  = (HW+1)'(TAPE_LEN);
    localparam logic [STEP_W-1:0] STEP_MAX  = '1;

    state_t                state, state_nxt;
    logic [TAPE_LEN-1:0]   tape_r, tape_nxt;
    logic [HW-1:0]         head_r, head_nxt;
    logic [Q_W-1:0]        q_r, q_nxt;
    logic [STEP_W-1:0]     steps_r, steps_nxt;
    logic [1:0]            err_r, err_nxt;

    logic [Q_W+CFG_EXTRA_W-1:0] entry;
    logic                  halt;
    logic                  wr_sym;
    logic [1:0]            mv;
    logic [Q_W-1:0]        next_q;
    logic                  tbl_we;
    logic                  do_step;
    logic                  head_bad;
    logic                  hit_bound;

    // The table is frozen for the whole run so a transition never sees a half-updated program.
    assign tbl_we = bus.cfg_we && (state != ST_RUN);

    turing_table #(.Q_W(Q_W)) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr ({q_r, tape_r[head_r]}),
        .rdata (entry)
    );

    assign halt   = entry[Q_W+CFG_HALT_OFS];
    assign wr_sym = entry[Q_W+CFG_WR_OFS];
    assign mv     = entry[Q_W+CFG_MOVE_OFS +: 2];
    assign next_q = entry[CFG_NEXTQ_LSB +: Q_W];

`ifdef TURING_SINGLE_STEP_EN
    assign do_step = bus.step_req;
`else
    assign do_step = 1'b1;
`endif

    assign head_bad  = {1'b0, bus.head_init} >= TAPE_END;
    assign hit_bound = ((mv == MV_RIGHT) && (head_r == LAST_CELL)) ||
                       ((mv == MV_LEFT)  && (head_r == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tape_nxt  = tape_r;
        head_nxt  = head_r;
        q_nxt     = q_r;
        steps_nxt = steps_r;
        err_nxt   = err_r;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    tape_nxt  = bus.tape_in;
                    head_nxt  = bus.head_init;
                    q_nxt     = '0;
                    steps_nxt = '0;
                    err_nxt   = ERR_OK;
                    if (head_bad) begin
                        state_nxt = ST_DONE;
                        err_nxt   = ERR_BOUND;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (do_step) begin
                    tape_nxt[head_r] = wr_sym;
                    q_nxt            = next_q;
                    steps_nxt        = steps_r + 1'b1;
                    // Halt beats boundary beats timeout; halt and boundary keep the head in place.
                    if (halt) begin
                        state_nxt = ST_DONE;
                        err_nxt   = ERR_OK;
                    end else if (hit_bound) begin
                        state_nxt = ST_DONE;
                        err_nxt   = ERR_BOUND;
                    end else begin
                        if (mv == MV_RIGHT) begin
                            head_nxt = head_r + 1'b1;
                        end else if (mv == MV_LEFT) begin
                            head_nxt = head_r - 1'b1;
                        end
                        if (steps_nxt == STEP_MAX) begin
                            state_nxt = ST_DONE;
                            err_nxt   = ERR_TIMEOUT;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tape_r  <= '0;
            head_r  <= '0;
            q_r     <= '0;
            steps_r <= '0;
            err_r   <= ERR_OK;
        end else begin
            tape_r  <= tape_nxt;
            head_r  <= head_nxt;
            q_r     <= q_nxt;
            steps_r <= steps_nxt;
            err_r   <= err_nxt;
        end
    end

    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);
    assign bus.err      = err_r;
    assign bus.tape_out = tape_r;
    assign bus.head     = head_r;
    assign bus.q        = q_r;
    assign bus.steps    = steps_r;

endmodule

// File: tb/tb_turing_seq.sv
// Bench for turing_seq: directed vector table, multi-cycle corner sequences,
// and random programs compared against a loop-based Turing-machine model.
module tb_turing_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turing_seq_if bus ();
    turing_seq dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef logic [7:0][5:0] prog_t;
    typedef struct {
        prog_t      prog;
        logic [9:0] tin;
        logic [3:0] hinit;
        logic [1:0] err;
        logic [9:0] tape;
        logic [3:0] head;
        logic       chk_head;
        logic [1:0] q;
        int         steps;
    } vec_t;

    vec_t  vecs[5];
    prog_t scan_p, left_p, zero_p;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic program_tbl(input prog_t p);
        for (int i = 0; i < 8; i++) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 3'(i);
            bus.cfg_data = p[i];
            @(posedge clk); #1;
        end
        bus.cfg_we = 1'b0;
    endtask

    // Start a run and wait for done; lat counts edges after the load edge.
    task automatic run(input logic [9:0] tin, input logic [3:0] hi,
                       output int lat, output int bcyc);
        bus.tape_in   = tin;
        bus.head_init = hi;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat  = 0;
        bcyc = bus.busy ? 1 : 0;
        while (!bus.done && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) bcyc++;
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL run_timeout: done never rose within %0d cycles", lat);
        end
    endtask

    task automatic check_result(input string tag, input logic [1:0] e, input logic [9:0] t,
                                input logic [3:0] h, input logic chk_h, input logic [1:0] qq,
                                input int st, input int lat, input int bcyc);
        chk({tag, ".done"},  {31'd0, bus.done}, 32'd1);
        chk({tag, ".busy"},  {31'd0, bus.busy}, 32'd0);
        chk({tag, ".err"},   {30'd0, bus.err}, {30'd0, e});
        chk({tag, ".tape"},  {22'd0, bus.tape_out}, {22'd0, t});
        if (chk_h) chk({tag, ".head"}, {28'd0, bus.head}, {28'd0, h});
        chk({tag, ".q"},     {30'd0, bus.q}, {30'd0, qq});
        chk({tag, ".steps"}, {24'd0, bus.steps}, st);
        chk({tag, ".latency"}, lat, st);
        chk({tag, ".busy_cycles"}, bcyc, st);
    endtask

    // Reference: interpret the program directly on an array tape.
    task automatic model(input prog_t p, input logic [9:0] tin, input int hi,
                         output logic [9:0] t, output int h, output int qq,
                         output int st, output logic [1:0] e);
        logic [5:0] ent;
        int mv;
        t = tin; h = hi; qq = 0; st = 0; e = 2'b00;
        if (hi >= 10) begin
            e = 2'b01;
        end else begin
            for (int g = 0; g < 300; g++) begin
                ent   = p[qq * 2 + int'(t[h])];
                t[h]  = ent[4];
                qq    = int'(ent[1:0]);
                st    = st + 1;
                mv    = int'(ent[3:2]);
                if (ent[5]) begin e = 2'b00; break; end
                if ((mv == 1 && h == 9) || (mv == 2 && h == 0)) begin e = 2'b01; break; end
                if (mv == 1) h = h + 1;
                else if (mv == 2) h = h - 1;
                if (st == 255) begin e = 2'b10; break; end
            end
        end
    endtask

    initial begin
        int lat, bcyc;
        logic [9:0] mt;
        int mh, mq, ms;
        logic [1:0] me;
        prog_t rp;
        logic [9:0] rt;
        logic [3:0] rh;

        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.start = 1'b0; bus.tape_in = '0; bus.head_init = '0;
`ifdef TURING_SINGLE_STEP_EN
        bus.step_req = 1'b1;
`endif

        for (int i = 0; i < 8; i++) begin
            scan_p[i] = 6'b100000;
            zero_p[i] = 6'b000000;
            left_p[i] = 6'b100000;
        end
        scan_p[0] = 6'b110000;
        scan_p[1] = 6'b010100;
        left_p[0] = 6'b001000;
        left_p[1] = 6'b011000;

        vecs[0] = '{scan_p, 10'b0000000111, 4'd0, 2'b00, 10'b0000001111, 4'd3, 1'b1, 2'd0, 4};
        vecs[1] = '{scan_p, 10'b1111111111, 4'd0, 2'b01, 10'b1111111111, 4'd9, 1'b1, 2'd0, 10};
        vecs[2] = '{left_p, 10'b1010010011, 4'd0, 2'b01, 10'b1010010011, 4'd0, 1'b1, 2'd0, 1};
        vecs[3] = '{zero_p, 10'b1111100000, 4'd5, 2'b10, 10'b1111000000, 4'd5, 1'b1, 2'd0, 255};
        vecs[4] = '{scan_p, 10'b0101010101, 4'd10, 2'b01, 10'b0101010101, 4'd0, 1'b0, 2'd0, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy",  {31'd0, bus.busy}, 32'd0);
        chk("reset.done",  {31'd0, bus.done}, 32'd0);
        chk("reset.err",   {30'd0, bus.err}, 32'd0);
        chk("reset.tape",  {22'd0, bus.tape_out}, 32'd0);
        chk("reset.head",  {28'd0, bus.head}, 32'd0);
        chk("reset.q",     {30'd0, bus.q}, 32'd0);
        chk("reset.steps", {24'd0, bus.steps}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            program_tbl(vecs[v].prog);
            run(vecs[v].tin, vecs[v].hinit, lat, bcyc);
            check_result($sformatf("vec%0d", v), vecs[v].err, vecs[v].tape, vecs[v].head,
                         vecs[v].chk_head, vecs[v].q, vecs[v].steps, lat, bcyc);
        end

        // Abort mid-run, then restart on the preserved table.
        program_tbl(scan_p);
        bus.tape_in = 10'b0000000111; bus.head_init = 4'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("load.busy", {31'd0, bus.busy}, 32'd1);
        chk("load.done", {31'd0, bus.done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort.pre_steps", {24'd0, bus.steps}, 32'd2);
        rst = 1'b1;
        #1;
        chk("abort.busy",  {31'd0, bus.busy}, 32'd0);
        chk("abort.tape",  {22'd0, bus.tape_out}, 32'd0);
        chk("abort.head",  {28'd0, bus.head}, 32'd0);
        chk("abort.steps", {24'd0, bus.steps}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(10'b0000000111, 4'd0, lat, bcyc);
        check_result("restart", 2'b00, 10'b0000001111, 4'd3, 1'b1, 2'd0, 4, lat, bcyc);

        // cfg_we and start during RUN must be ignored.
        bus.tape_in = 10'b0000000111; bus.head_init = 4'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 6'b000000;
        bus.start = 1'b1; bus.tape_in = 10'b1111111111; bus.head_init = 4'd9;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0; bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 400) begin @(posedge clk); #1; lat++; end
        chk("ignore.err",   {30'd0, bus.err}, 32'd0);
        chk("ignore.tape",  {22'd0, bus.tape_out}, 32'h00F);
        chk("ignore.steps", {24'd0, bus.steps}, 32'd4);
        run(10'b0000000111, 4'd0, lat, bcyc);
        check_result("ignore_rerun", 2'b00, 10'b0000001111, 4'd3, 1'b1, 2'd0, 4, lat, bcyc);

        // Write and start on the same edge: the run uses the new entry.
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 6'b100000;
        run(10'b0000000111, 4'd0, lat, bcyc);
        bus.cfg_we = 1'b0;
        check_result("wr_start", 2'b00, 10'b0000000111, 4'd3, 1'b1, 2'd0, 4, lat, bcyc);

`ifdef TURING_SINGLE_STEP_EN
        program_tbl(scan_p);
        bus.step_req = 1'b0;
        bus.tape_in = 10'b0000000111; bus.head_init = 4'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk($sformatf("ss.hold%0d", p), {24'd0, bus.steps}, p);
            end
            bus.step_req = 1'b1;
            @(posedge clk); #1;
            bus.step_req = 1'b0;
            chk($sformatf("ss.step%0d", p), {24'd0, bus.steps}, p + 1);
        end
        chk("ss.done", {31'd0, bus.done}, 32'd1);
        chk("ss.tape", {22'd0, bus.tape_out}, 32'h00F);
        chk("ss.head", {28'd0, bus.head}, 32'd3);
        chk("ss.err",  {30'd0, bus.err}, 32'd0);
        bus.step_req = 1'b1;
`endif

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 8; i++) begin
                rp[i] = 6'($urandom);
                rp[i][5] = ($urandom_range(0, 3) == 0);
            end
            rt = 10'($urandom);
            rh = 4'($urandom_range(0, 10));
            program_tbl(rp);
            model(rp, rt, int'(rh), mt, mh, mq, ms, me);
            run(rt, rh, lat, bcyc);
            check_result($sformatf("rand%0d", r), me, mt, 4'(mh), (rh < 4'd10), 2'(mq),
                         ms, lat, bcyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/turing_seq.md
Name: turing_seq

Overview:
- Synchronous, programmable Turing-machine sequencer.
- Holds a TAPE_LEN-cell binary tape, a head pointer and a control state. Executes one transition per clock from a writable transition table.
- Runs until a halt entry, a tape-boundary violation or a step-limit timeout.
- Acts as the controller for the tape datapath: loads the tape, sequences read/write/move, and reports completion to a host or testbench.

Parameters:
- TAPE_LEN, 10, number of tape cells; cell 0 is tape bit 0.
- Q_W, 2, control-state width; 2**Q_W states.
- STEP_W, 8, step-counter width; step limit is 2**STEP_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write one transition-table entry.
- cfg_addr  in  Q_W+1  entry index {state, read_symbol}.
- cfg_data  in  Q_W+4  entry {halt[1], wr_sym[1], move[2], next_q[Q_W]}, MSB first.
- start  in  1  begin a run.
- tape_in  in  TAPE_LEN  initial tape, loaded on start.
- head_init  in  $clog2(TAPE_LEN)  initial head position.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- err  out  2  00 halt ok, 01 boundary, 10 timeout.
- tape_out  out  TAPE_LEN  live tape contents.
- head  out  $clog2(TAPE_LEN)  current head position.
- q  out  Q_W  current control state.
- steps  out  STEP_W  transitions executed.

Behaviour:
- Reset (async, rst=1): busy=0, done=0, err=00, tape_out=0, head=0, q=0, steps=0, FSM=IDLE. Table contents are not reset (RAM-like) and must be reprogrammed after power-up.
- FSM states:
  - IDLE: waits for start.
  - RUN: one transition per clk.
  - DONE: outputs frozen, done=1.
- start sampled high in IDLE or DONE:
  - Next edge: tape<=tape_in, head<=head_init, q<=0, steps<=0, done<=0, err<=00, FSM<=RUN, busy=1.
  - head_init >= TAPE_LEN immediately ends with err=01, done=1, no step executed.
- start while in RUN is ignored.
- Each RUN edge:
  - Reads entry at {q, tape[head]}.
  - Writes tape[head]<=wr_sym.
  - Sets q<=next_q.
  - steps<=steps+1.
  - Applies move: 00 stay, 01 right (+1), 10 left (-1), 11 stay.
- Halt entry (halt=1): write and state update still apply, head does not move. Next state is DONE, err=00.
- Boundary: a move right from cell TAPE_LEN-1 or left from cell 0 still writes and updates q. head stays put, FSM<=DONE, err=01.
- Timeout: if a non-halting, non-boundary step makes steps reach 2**STEP_W-1, FSM<=DONE, err=10.
- Priority within one step: halt > boundary > timeout.
- Latency: with start at edge 0, the first transition happens at edge 2. A run of N transitions asserts done after edge N+1.
- cfg_we:
  - Honoured in IDLE and DONE.
  - Ignored while busy; running table is never modified mid-run.
  - cfg_we and start on the same edge: the write lands first and the run begins with the new table on the following edge.
- Reset mid-run aborts immediately to reset values; the table is preserved.

Optional Feature:
- TURING_SINGLE_STEP_EN defined:
  - Adds input step_req (1 bit).
  - In RUN, a transition executes only on edges where step_req=1; otherwise all state is held. steps counts executed transitions only.
- Undefined: no step_req port; one transition per clk in RUN.

Decomposition:
- Package turing_pkg holds:
  - move encodings MV_STAY/MV_RIGHT/MV_LEFT.
  - err codes ERR_OK/ERR_BOUND/ERR_TIMEOUT.
  - FSM state enum.
  - cfg_data field offsets.
- One sub-module, turing_table: 2**(Q_W+1) x (Q_W+4) register file with synchronous write and combinational read.

Test Plan:
- Scan-and-append. Program (q0,1)->{0,1,01,q0} and (q0,0)->{1,1,00,q0}; tape_in=10'b0000000111, head_init=0. Required: done after 4 steps, tape_out=10'b0000001111, head=3, steps=4, err=00.
- Boundary right. Same program, tape_in=all ones. Required: err=01, head=9, steps=10, tape unchanged.
- Boundary left. Program (q0,x) move=10; head_init=0. Required: err=01 after 1 step, head=0.
- Timeout. Every entry {0,0,00,q0}. Required: err=10, steps=255, busy high for 255 cycles.
- Abort and ignore. Assert rst at step 2 of the scan test: all outputs return to reset values. Restart without reprogramming: same result as the scan test. cfg_we and start during RUN: no effect.
- Single-step (TURING_SINGLE_STEP_EN). Pulse step_req 4 times with 3-cycle gaps. Required: state frozen between pulses, result identical to the scan test.
